hzd_ctrl_unit: RTL and testbench
================================

Name: hzd_ctrl_unit

Overview:
Parametrised pipeline hazard controller. It generalises load-use, flag-use and control hazard detection into a stateful unit. A per-register scoreboard tracks multi-cycle load latency, a counter tracks flag-producer latency, and a small FSM sequences control flushes and halt. It sits beside the ID stage and drives the PC/IF-ID stall, the ID/EX bubble and the IF-ID flush.

Parameters:
REG_ADDR_W, 4, register specifier width; NUM_REGS = 2**REG_ADDR_W; register 0 is hardwired zero
MEM_LAT, 1, cycles a load result stays unforwardable after issue (1..7)
FLAG_LAT, 1, cycles flags stay stale after a flag-updating instruction issues (1..7)
FLUSH_CYC, 1, cycles IF-ID is flushed after a control redirect (1..7)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a valid instruction
id_rs  in  REG_ADDR_W  source register 1
id_rt  in  REG_ADDR_W  source register 2
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt
id_rd  in  REG_ADDR_W  destination register
id_mem_to_reg  in  1  instruction is a load
id_flag_upd  in  3  {z,v,n} update enables of the instruction
id_branch_cntl  in  1  instruction reads flags (conditional branch)
id_hlt  in  1  instruction is HLT
ctrl_redirect  in  1  taken branch/call/ret resolved this cycle
stall  out  1  hold PC and IF-ID
bubble  out  1  insert NOP into ID/EX
flush  out  1  kill the IF-ID contents
halted  out  1  pipeline halted
hzd_cause  out  3  {ctrl, flag, mem}; bits are individually set

Behaviour:
- Reset (rst_n=0, async): all scoreboard counters = 0, flag_cnt = 0, flush_cnt = 0, FSM = RUN.
- Reset values of outputs: stall=0, bubble=0, flush=0, halted=0, hzd_cause=0.
- State:
  - sb_cnt[NUM_REGS], 3 bits each
  - flag_cnt, 3 bits
  - flush_cnt, 3 bits
  - FSM {RUN, FLUSH, HALT}
- Issue event: issue = id_valid & ~stall & ~flush & (FSM != HALT).
- Combinational hazards, evaluated from current state:
  - mem_hzd = id_valid & ((id_uses_rs & id_rs!=0 & sb_cnt[id_rs]!=0) | (id_uses_rt & id_rt!=0 & sb_cnt[id_rt]!=0))
  - flag_hzd = id_valid & id_branch_cntl & flag_cnt!=0
- Outputs:
  - flush = ctrl_redirect | (FSM==FLUSH). flush has priority: when it is 1, stall=0 and the ID instruction is discarded (not issued).
  - stall = ~flush & (mem_hzd | flag_hzd | FSM==HALT)
  - bubble = stall | flush
  - halted = (FSM==HALT)
  - hzd_cause = {flush, flag_hzd & ~flush, mem_hzd & ~flush}
- Scoreboard update per clock:
  - Every nonzero sb_cnt decrements by 1.
  - On issue with id_mem_to_reg & id_rd!=0: sb_cnt[id_rd] <= MEM_LAT. A set overrides a simultaneous decrement of the same entry.
  - sb_cnt[0] is never written and always reads 0.
- Flag counter per clock:
  - A nonzero flag_cnt decrements by 1.
  - On issue with |id_flag_upd: flag_cnt <= FLAG_LAT. The set wins over the decrement.
- FSM:
  - RUN to FLUSH: ctrl_redirect & FLUSH_CYC>1; flush_cnt <= FLUSH_CYC-1.
  - RUN stays in RUN: ctrl_redirect & FLUSH_CYC==1 (single-cycle flush, combinational only).
  - FLUSH: flush_cnt decrements each cycle; returns to RUN when the count reaches 1 and there is no new redirect.
  - FLUSH, new ctrl_redirect: restarts flush_cnt <= FLUSH_CYC-1.
  - RUN to HALT: issue & id_hlt.
  - HALT is absorbing until reset. In HALT, ctrl_redirect is ignored (flush=0), stall=1, bubble=1, and no scoreboard sets occur, though counters still drain.
- An ID instruction stalled on a hazard is re-evaluated every cycle. It issues on the first cycle its hazards clear.
- Simultaneous mem_hzd and flag_hzd: stall=1 and both cause bits are set.
- Reset asserted mid-stall or mid-flush clears everything immediately. The next cycle after release behaves as from power-up.

Test Plan:
1. MEM_LAT=1: issue load rd=3, next cycle ID id_rs=3, id_uses_rs=1 -> stall=1, bubble=1, hzd_cause=3'b001 for 1 cycle; then stall=0 and the instruction issues.
2. MEM_LAT=3: load rd=5, then a consumer of rt=5 -> stall held 3 cycles. The same case with rd=0 -> no stall.
3. FLAG_LAT=2: issue id_flag_upd=3'b100, then id_branch_cntl=1 -> stall 2 cycles with hzd_cause=3'b010. With id_flag_upd=0 -> no stall.
4. FLUSH_CYC=3: ctrl_redirect pulse -> flush=1 for 3 cycles. A second redirect in cycle 2 extends flush to cycle 4. A load-use hazard concurrent with flush -> stall=0, hzd_cause=3'b100.
5. Issue HLT -> halted=1 and stall=1 from the next cycle. A later ctrl_redirect -> flush stays 0. Pulse rst_n=0 -> all outputs 0 asynchronously.
6. Load rd=4 issued the same cycle sb_cnt[4]=1 is decrementing -> sb_cnt[4]=MEM_LAT afterwards (set wins), verified by stall length on a following consumer of r4.

Source files
------------

// File: rtl/hzd_ctrl_unit.sv
// hzd_ctrl_unit: ID-stage hazard controller with a load scoreboard, a flag-staleness counter and a flush/halt FSM
// Ports: clk/rst_n (async active-low); id_* describe the instruction in ID; ctrl_redirect is a resolved taken branch/call/ret;
// stall holds PC and IF-ID, bubble inserts a NOP into ID/EX, flush kills IF-ID, halted flags HALT, hzd_cause = {ctrl, flag, mem}.
module hzd_ctrl_unit #(
  parameter int REG_ADDR_W = 4,
  parameter int MEM_LAT    = 1,
  parameter int FLAG_LAT   = 1,
  parameter int FLUSH_CYC  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_mem_to_reg,
  input  logic [2:0]            id_flag_upd,
  input  logic                  id_branch_cntl,
  input  logic                  id_hlt,
  input  logic                  ctrl_redirect,
  output logic                  stall,
  output logic                  bubble,
  output logic                  flush,
  output logic                  halted,
  output logic [2:0]            hzd_cause
);
  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam logic [2:0] MEM_L = 3'(MEM_LAT);
  localparam logic [2:0] FLAG_L = 3'(FLAG_LAT);
  localparam logic [2:0] FLUSH_M1 = 3'(FLUSH_CYC - 1);
  localparam bit MULTI_FLUSH = FLUSH_CYC > 1;
  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_e;
  state_e state_q, state_d;
  logic [2:0] sb_q [NUM_REGS];
  logic [2:0] sb_d [NUM_REGS];
  logic [2:0] flag_cnt_q, flag_cnt_d, flush_cnt_q, flush_cnt_d;
  logic issue, ld_set, mem_hzd, flag_hzd, rs_busy, rt_busy;
  assign rs_busy  = id_uses_rs && id_rs != '0 && sb_q[id_rs] != '0;
  assign rt_busy  = id_uses_rt && id_rt != '0 && sb_q[id_rt] != '0;
  assign mem_hzd  = id_valid && (rs_busy || rt_busy);
  assign flag_hzd = id_valid && id_branch_cntl && flag_cnt_q != '0;
  assign issue    = id_valid && !stall && !flush && state_q != HALT;
  // rd=0 never allocates, so entry 0 only ever decays from its reset value of zero
  assign ld_set   = issue && id_mem_to_reg && id_rd != '0;
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++)
      sb_d[i] = (ld_set && id_rd == REG_ADDR_W'(i)) ? MEM_L : (sb_q[i] != '0 ? sb_q[i] - 3'd1 : '0);
    flag_cnt_d = (issue && |id_flag_upd) ? FLAG_L : (flag_cnt_q != '0 ? flag_cnt_q - 3'd1 : '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      flag_cnt_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) sb_q[i] <= '0;
    end else begin
      flag_cnt_q <= flag_cnt_d;
      for (int i = 0; i < NUM_REGS; i++) sb_q[i] <= sb_d[i];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  // The redirect cycle itself flushes combinationally, so FLUSH only covers the remaining FLUSH_CYC-1 cycles
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      RUN:
        if (ctrl_redirect && MULTI_FLUSH) begin
          state_d     = FLUSH;
          flush_cnt_d = FLUSH_M1;
        end else if (issue && id_hlt) state_d = HALT;
      FLUSH:
        if (ctrl_redirect) flush_cnt_d = FLUSH_M1;
        else if (flush_cnt_q <= 3'd1) begin
          state_d     = RUN;
          flush_cnt_d = '0;
        end else flush_cnt_d = flush_cnt_q - 3'd1;
      default: ;
    endcase
  end
  always_comb begin
    flush     = (ctrl_redirect && state_q != HALT) || state_q == FLUSH;
    stall     = !flush && (mem_hzd || flag_hzd || state_q == HALT);
    bubble    = stall || flush;
    halted    = state_q == HALT;
    hzd_cause = {flush, flag_hzd && !flush, mem_hzd && !flush};
  end
endmodule

// File: tb/tb_hzd_ctrl_unit.sv
// tb_hzd_ctrl_unit: directed checks of hzd_ctrl_unit with a short-latency and a long-latency instance
module tb_hzd_ctrl_unit;
  localparam logic [6:0] IDLE = 7'b0000000;
  localparam logic [6:0] MEM  = 7'b1100001;
  localparam logic [6:0] FLG  = 7'b1100010;
  localparam logic [6:0] BOTH = 7'b1100011;
  localparam logic [6:0] FLS  = 7'b0110100;
  localparam logic [6:0] HLT  = 7'b1101000;
  logic clk = 1'b0, rst_n;
  logic id_valid, id_uses_rs, id_uses_rt, id_mem_to_reg, id_branch_cntl, id_hlt, ctrl_redirect;
  logic [3:0] id_rs, id_rt, id_rd;
  logic [2:0] id_flag_upd;
  logic a_stall, a_bubble, a_flush, a_halted, b_stall, b_bubble, b_flush, b_halted;
  logic [2:0] a_cause, b_cause;
  logic [6:0] o_a, o_b;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  assign o_a = {a_stall, a_bubble, a_flush, a_halted, a_cause};
  assign o_b = {b_stall, b_bubble, b_flush, b_halted, b_cause};
  hzd_ctrl_unit #(.REG_ADDR_W(4), .MEM_LAT(1), .FLAG_LAT(1), .FLUSH_CYC(1)) u_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_mem_to_reg(id_mem_to_reg),
    .id_flag_upd(id_flag_upd), .id_branch_cntl(id_branch_cntl), .id_hlt(id_hlt),
    .ctrl_redirect(ctrl_redirect), .stall(a_stall), .bubble(a_bubble), .flush(a_flush),
    .halted(a_halted), .hzd_cause(a_cause));
  hzd_ctrl_unit #(.REG_ADDR_W(4), .MEM_LAT(3), .FLAG_LAT(2), .FLUSH_CYC(3)) u_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_mem_to_reg(id_mem_to_reg),
    .id_flag_upd(id_flag_upd), .id_branch_cntl(id_branch_cntl), .id_hlt(id_hlt),
    .ctrl_redirect(ctrl_redirect), .stall(b_stall), .bubble(b_bubble), .flush(b_flush),
    .halted(b_halted), .hzd_cause(b_cause));
  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic idle();
    id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; id_mem_to_reg = 0; id_branch_cntl = 0;
    id_hlt = 0; ctrl_redirect = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_flag_upd = 0;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    idle();
    rst_n = 0;
    #2 chk("rst_a", o_a, IDLE); chk("rst_b", o_b, IDLE);
    cyc(); cyc(); rst_n = 1; cyc();
    id_valid = 1; id_mem_to_reg = 1; id_rd = 3;
    #1 chk("ld3_a", o_a, IDLE);
    cyc(); idle(); id_valid = 1; id_uses_rs = 1; id_rs = 3;
    #1 chk("use3_a0", o_a, MEM); chk("use3_b0", o_b, MEM);
    cyc(); #1 chk("use3_a1", o_a, IDLE); chk("use3_b1", o_b, MEM);
    cyc(); #1 chk("use3_b2", o_b, MEM);
    cyc(); #1 chk("use3_b3", o_b, IDLE);
    cyc(); idle(); id_valid = 1; id_mem_to_reg = 1; id_rd = 5;
    cyc(); idle(); id_valid = 1; id_uses_rt = 1; id_rt = 5;
    #1 chk("use5_a0", o_a, MEM);
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("use5_b%0d", k), o_b, MEM);
      cyc();
    end
    #1 chk("use5_b3", o_b, IDLE);
    cyc(); idle(); id_valid = 1; id_mem_to_reg = 1; id_rd = 0;
    cyc(); idle(); id_valid = 1; id_uses_rt = 1; id_rt = 0;
    #1 chk("use0_b", o_b, IDLE);
    cyc(); idle(); id_valid = 1; id_flag_upd = 3'b100;
    cyc(); idle(); id_valid = 1; id_branch_cntl = 1;
    #1 chk("br_a0", o_a, FLG); chk("br_b0", o_b, FLG);
    cyc(); #1 chk("br_a1", o_a, IDLE); chk("br_b1", o_b, FLG);
    cyc(); #1 chk("br_b2", o_b, IDLE);
    cyc(); idle(); id_valid = 1;
    cyc(); idle(); id_valid = 1; id_branch_cntl = 1;
    #1 chk("br_nf_b", o_b, IDLE);
    cyc(); idle(); id_valid = 1; id_mem_to_reg = 1; id_rd = 6; id_flag_upd = 3'b001;
    cyc(); idle(); id_valid = 1; id_branch_cntl = 1; id_uses_rs = 1; id_rs = 6;
    #1 chk("mix_a0", o_a, BOTH); chk("mix_b0", o_b, BOTH);
    cyc(); #1 chk("mix_a1", o_a, IDLE); chk("mix_b1", o_b, BOTH);
    cyc(); #1 chk("mix_b2", o_b, MEM);
    cyc(); #1 chk("mix_b3", o_b, IDLE);
    cyc(); idle(); ctrl_redirect = 1;
    #1 chk("fl_a0", o_a, FLS); chk("fl_b0", o_b, FLS);
    cyc(); ctrl_redirect = 0;
    #1 chk("fl_a1", o_a, IDLE); chk("fl_b1", o_b, FLS);
    cyc(); #1 chk("fl_b2", o_b, FLS);
    cyc(); #1 chk("fl_b3", o_b, IDLE);
    cyc(); ctrl_redirect = 1;
    cyc(); ctrl_redirect = 0;
    cyc(); ctrl_redirect = 1;
    #1 chk("flx_b2", o_b, FLS);
    cyc(); ctrl_redirect = 0;
    #1 chk("flx_b3", o_b, FLS);
    cyc(); #1 chk("flx_b4", o_b, FLS);
    cyc(); #1 chk("flx_b5", o_b, IDLE);
    cyc(); idle(); id_valid = 1; id_mem_to_reg = 1; id_rd = 7;
    cyc(); idle(); id_valid = 1; id_uses_rs = 1; id_rs = 7; ctrl_redirect = 1;
    #1 chk("flmem_a", o_a, FLS); chk("flmem_b", o_b, FLS);
    cyc(); ctrl_redirect = 0;
    #1 chk("flmem_a1", o_a, IDLE); chk("flmem_b1", o_b, FLS);
    cyc(); idle();
    repeat (5) cyc();
    id_valid = 1; id_mem_to_reg = 1; id_rd = 4;
    cyc(); idle();
    cyc(); cyc();
    id_valid = 1; id_mem_to_reg = 1; id_rd = 4;
    #1 chk("reld4_b", o_b, IDLE);
    cyc(); idle(); id_valid = 1; id_uses_rs = 1; id_rs = 4;
    #1 chk("set_a0", o_a, MEM); chk("set_b0", o_b, MEM);
    cyc(); #1 chk("set_a1", o_a, IDLE); chk("set_b1", o_b, MEM);
    cyc(); #1 chk("set_b2", o_b, MEM);
    cyc(); #1 chk("set_b3", o_b, IDLE);
    cyc(); idle(); id_valid = 1; id_hlt = 1;
    #1 chk("hlt_iss_b", o_b, IDLE);
    cyc(); idle();
    #1 chk("hlt_a", o_a, HLT); chk("hlt_b", o_b, HLT);
    ctrl_redirect = 1;
    #1 chk("hlt_rd_a", o_a, HLT); chk("hlt_rd_b", o_b, HLT);
    cyc(); #1 chk("hlt_keep_b", o_b, HLT);
    idle();
    #1 rst_n = 0;
    #1 chk("arst_a", o_a, IDLE); chk("arst_b", o_b, IDLE);
    cyc(); rst_n = 1;
    cyc(); id_valid = 1; id_mem_to_reg = 1; id_rd = 3;
    cyc(); idle(); id_valid = 1; id_uses_rs = 1; id_rs = 3;
    #1 chk("post_a0", o_a, MEM);
    cyc(); #1 chk("post_a1", o_a, IDLE);
    idle();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
